mult4u_sched: RTL and testbench

MULT4U_SCHED -- requirements
Module: mult4u_sched

---
 rtl/mult4u_sched.sv | 128 ++++++++++++
 tb/tb_mult4u_sched.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mult4u_sched.sv
// Dual-requester scheduler for a shared 4x4 multiplier with duplex compare.
// Ports: req0/req1 valid/ready/a/b in, mult_a/mult_b/mult_p, rsp_* out, err_cnt.
module mult4u_sched #(
  parameter int MAX_RETRY = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  input  logic       req1_valid,
  output logic       req0_ready,
  output logic       req1_ready,
  input  logic [3:0] req0_a,
  input  logic [3:0] req0_b,
  input  logic [3:0] req1_a,
  input  logic [3:0] req1_b,
  output logic [3:0] mult_a,
  output logic [3:0] mult_b,
  input  logic [7:0] mult_p,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_id,
  output logic [7:0] rsp_p,
  output logic       rsp_err,
  output logic [7:0] err_cnt
);

  typedef enum logic [2:0] {
    IDLE, RUN1, RUN2, CHECK, RESP
  } state_t;

  state_t     state, state_d;
  logic       last_grant;
  logic       id_q;
  logic       err_q;
  logic [2:0] retry;
  logic [3:0] a_q, b_q;
  logic [7:0] p1, p2;
  logic [7:0] cnt_q;
  logic       both;
  logic       sel;
  logic       accept;
  logic       mism;
  logic       can_retry;

  // sel picks requester 1 when it alone is valid,
  // or on a tie when requester 0 was granted last.
  always_comb begin
    both       = req0_valid & req1_valid;
    sel        = both ? ~last_grant : req1_valid;
    req0_ready = (state == IDLE) & req0_valid & ~sel;
    req1_ready = (state == IDLE) & req1_valid & sel;
    accept     = req0_ready | req1_ready;
    mism       = (p1 != p2);
    can_retry  = (retry < 3'(MAX_RETRY));
  end

  always_comb begin
    state_d   = state;
    mult_a    = 4'd0;
    mult_b    = 4'd0;
    rsp_valid = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) state_d = RUN1;
      end
      RUN1: begin
        mult_a  = a_q;
        mult_b  = b_q;
        state_d = RUN2;
      end
      RUN2: begin
        // Swapped order so an order-sensitive
        // fault shows up as a mismatch.
        mult_a  = b_q;
        mult_b  = a_q;
        state_d = CHECK;
      end
      CHECK: begin
        if (mism && can_retry) state_d = RUN1;
        else                   state_d = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      id_q       <= 1'b0;
      err_q      <= 1'b0;
      retry      <= 3'd0;
      a_q        <= 4'd0;
      b_q        <= 4'd0;
      p1         <= 8'd0;
      p2         <= 8'd0;
      cnt_q      <= 8'd0;
    end else begin
      state <= state_d;
      if (state == IDLE && accept) begin
        a_q        <= req1_ready ? req1_a : req0_a;
        b_q        <= req1_ready ? req1_b : req0_b;
        id_q       <= req1_ready;
        last_grant <= req1_ready;
        retry      <= 3'd0;
      end
      if (state == RUN1) p1 <= mult_p;
      if (state == RUN2) p2 <= mult_p;
      if (state == CHECK) begin
        err_q <= mism & ~can_retry;
        if (mism && cnt_q != 8'hFF)
          cnt_q <= cnt_q + 8'd1;
        if (mism && can_retry)
          retry <= retry + 3'd1;
      end
    end
  end

  assign rsp_id  = id_q;
  assign rsp_p   = p1;
  assign rsp_err = err_q;
  assign err_cnt = cnt_q;

endmodule

// File: tb/tb_mult4u_sched.sv
// Scoreboard bench for mult4u_sched with a behavioural multiplier model.
// Stimulus pushes expected responses; a negedge monitor pops and compares.
module tb_mult4u_sched;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0_valid, req1_valid;
  logic       req0_ready, req1_ready;
  logic [3:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0] mult_a, mult_b;
  logic [7:0] mult_p;
  logic       rsp_valid, rsp_ready;
  logic       rsp_id;
  logic [7:0] rsp_p;
  logic       rsp_err;
  logic [7:0] err_cnt;

  typedef struct {
    bit       id;
    bit [7:0] p;
    bit       err;
    bit [7:0] cnt;
    int       lat;
  } exp_t;

  exp_t exp_q[$];
  int   acc_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   mode = 0;
  int   fault_cnt = 0;

  mult4u_sched #(.MAX_RETRY(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_a(req1_a), .req1_b(req1_b),
    .mult_a(mult_a), .mult_b(mult_b), .mult_p(mult_p),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_p(rsp_p), .rsp_err(rsp_err),
    .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // mode 0: ideal, 1: zero once on (7,6), 2: order-dependent stuck
  always_comb begin
    mult_p = {4'd0, mult_a} * {4'd0, mult_b};
    if (mode == 1 && fault_cnt == 0 && mult_a == 4'd7 && mult_b == 4'd6)
      mult_p = 8'h00;
    if (mode == 2) begin
      if (mult_a == 4'd0 || mult_b == 4'd0) mult_p = 8'h00;
      else if (mult_a < mult_b)             mult_p = 8'h12;
      else                                  mult_p = 8'h21;
    end
  end

  always @(posedge clk)
    if (mode == 1 && mult_a == 4'd7 && mult_b == 4'd6)
      fault_cnt <= fault_cnt + 1;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor
  bit       in_rsp = 0;
  bit       s_id, s_err;
  bit [7:0] s_p;
  always @(negedge clk) begin
    if (!rst_n) begin
      acc_q.delete();
      in_rsp = 0;
    end else begin
      chk("ready_exclusive", int'(req0_ready & req1_ready), 0);
      if ((req0_valid && req0_ready) || (req1_valid && req1_ready))
        acc_q.push_back(cyc);
      if (rsp_valid && !in_rsp) begin
        in_rsp = 1;
        s_id = rsp_id; s_p = rsp_p; s_err = rsp_err;
        if (acc_q.size() == 0 || exp_q.size() == 0)
          chk("rsp_without_request", 1, 0);
        else
          chk("latency", cyc - acc_q.pop_front(), exp_q[0].lat);
      end else if (rsp_valid) begin
        chk("hold_id", int'(rsp_id), int'(s_id));
        chk("hold_p", int'(rsp_p), int'(s_p));
        chk("hold_err", int'(rsp_err), int'(s_err));
        chk("hold_ready", int'(req0_ready | req1_ready), 0);
      end
      if (rsp_valid && rsp_ready) begin
        in_rsp = 0;
        if (exp_q.size() == 0) begin
          chk("unexpected_rsp", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("rsp_id", int'(rsp_id), int'(e.id));
          chk("rsp_p", int'(rsp_p), int'(e.p));
          chk("rsp_err", int'(rsp_err), int'(e.err));
          chk("err_cnt", int'(err_cnt), int'(e.cnt));
        end
      end
    end
  end

  task automatic push(bit id, bit [7:0] p, bit err, bit [7:0] c, int lat);
    exp_t e;
    e.id = id; e.p = p; e.err = err; e.cnt = c; e.lat = lat;
    exp_q.push_back(e);
  endtask

  task automatic send(bit id, bit [3:0] a, bit [3:0] b);
    bit ok = 0;
    @(posedge clk); #1;
    if (id) begin req1_a = a; req1_b = b; req1_valid = 1; end
    else    begin req0_a = a; req0_b = b; req0_valid = 1; end
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = id ? (req1_valid && req1_ready) : (req0_valid && req0_ready);
    end
    if (!ok) chk("accept_timeout", 1, 0);
    @(posedge clk); #1;
    req0_valid = 0; req1_valid = 0;
    req0_a = 4'hA; req1_a = 4'hA; req0_b = 4'h5; req1_b = 4'h5;
  endtask

  task automatic drain();
    bit done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      done = (exp_q.size() == 0) && !rsp_valid;
    end
    if (!done) chk("drain_timeout", 1, 0);
  endtask

  task automatic do_reset();
    @(negedge clk); #1;
    rst_n = 0;
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1;
  endtask

  initial begin
    int gseq[4];
    int n;
    bit ok;
    rst_n = 0; rsp_ready = 1;
    req0_valid = 0; req1_valid = 0;
    req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
    repeat (3) @(negedge clk);
    chk("rst_rsp_valid", int'(rsp_valid), 0);
    chk("rst_rsp_p", int'(rsp_p), 0);
    chk("rst_rsp_id", int'(rsp_id), 0);
    chk("rst_rsp_err", int'(rsp_err), 0);
    chk("rst_err_cnt", int'(err_cnt), 0);
    chk("rst_mult_ab", int'({mult_a, mult_b}), 0);
    @(posedge clk); #1;
    rst_n = 1;

    // ideal 15*15
    push(0, 8'hE1, 0, 0, 4);
    send(0, 4'd15, 4'd15);
    drain();

    // both valid continuously: alternate from requester 0
    do_reset();
    push(0, 8'h0F, 0, 0, 4); push(1, 8'h3F, 0, 0, 4);
    push(0, 8'h0F, 0, 0, 4); push(1, 8'h3F, 0, 0, 4);
    req0_a = 3; req0_b = 5; req1_a = 7; req1_b = 9;
    req0_valid = 1; req1_valid = 1;
    n = 0;
    for (int i = 0; i < 100 && n < 4; i++) begin
      @(negedge clk);
      if (req0_valid && req0_ready) begin gseq[n] = 0; n++; end
      else if (req1_valid && req1_ready) begin gseq[n] = 1; n++; end
    end
    @(posedge clk); #1;
    req0_valid = 0; req1_valid = 0;
    chk("grant_count", n, 4);
    for (int i = 0; i < 4; i++)
      if (i < n) chk("grant_order", gseq[i], i % 2);
    drain();

    // transient zero in first RUN2 -> one retry
    mode = 1;
    push(0, 8'h2A, 0, 1, 7);
    send(0, 4'd6, 4'd7);
    drain();

    // order-dependent stuck output, exhausted retries, stalled response
    do_reset();
    mode = 2;
    rsp_ready = 0;
    push(0, 8'h12, 1, 3, 10);
    send(0, 4'd2, 4'd9);
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = rsp_valid;
    end
    if (!ok) chk("rsp_timeout", 1, 0);
    repeat (5) @(negedge clk);
    @(posedge clk); #1;
    rsp_ready = 1;
    @(posedge clk); #1;
    chk("released", int'(rsp_valid), 0);
    drain();

    // reset during RUN2 abandons the transaction
    mode = 0;
    send(0, 4'd3, 4'd4);
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = (mult_a == 4'd4) && (mult_b == 4'd3);
    end
    chk("reached_run2", int'(ok), 1);
    #1 rst_n = 0;
    #1;
    chk("abort_mult_ab", int'({mult_a, mult_b}), 0);
    chk("abort_rsp_valid", int'(rsp_valid), 0);
    chk("abort_rsp_p", int'(rsp_p), 0);
    chk("abort_err_cnt", int'(err_cnt), 0);
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1;
    repeat (10) @(negedge clk);
    push(1, 8'h1E, 0, 0, 4);
    send(1, 4'd5, 4'd6);
    drain();

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
